// File: rtl/sign_overlay_renderer_if.sv
// rtl/sign_overlay_renderer_if.sv - pixel request/result stream and bitmap ROM port bundle
interface sign_overlay_renderer_if #(
  parameter int COORD_WIDTH = 10,
  parameter int ADDR_WIDTH  = 17
);
  logic                   pix_valid_in;
  logic [COORD_WIDTH-1:0] pix_x;
  logic [COORD_WIDTH-1:0] pix_y;
  logic [15:0]            pix_in;
  logic [ADDR_WIDTH-1:0]  rom_addr;
  logic                   rom_data;
  logic                   pix_valid_out;
  logic [15:0]            pix_out;

  modport master (
    output pix_valid_in, pix_x, pix_y, pix_in, rom_data,
    input  rom_addr, pix_valid_out, pix_out
  );

  modport slave (
    input  pix_valid_in, pix_x, pix_y, pix_in, rom_data,
    output rom_addr, pix_valid_out, pix_out
  );
endinterface

// File: rtl/sign_overlay_renderer.sv
// rtl/sign_overlay_renderer.sv - 4-stage sign bitmap compositor over an RGB565 pixel stream
module sign_overlay_renderer #(
  parameter int ADDR_WIDTH  = 17,
  parameter int COORD_WIDTH = 10,
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic [COORD_WIDTH-1:0] cfg_x0,
  input  logic [COORD_WIDTH-1:0] cfg_y0,
  input  logic [15:0]            cfg_fg,
  input  logic [15:0]            cfg_bg,
  input  logic                   cfg_transparent,
  input  logic                   cfg_enable,
  sign_overlay_renderer_if.slave bus
);
  localparam int CW1 = COORD_WIDTH + 1;

  logic [COORD_WIDTH-1:0] x0_q, y0_q;
  logic [15:0]            fg_q, bg_q;
  logic                   tr_q, en_q;

  logic                   s1_valid, s1_inside;
  logic [15:0]            s1_pix;
  logic [COORD_WIDTH-1:0] s1_rx, s1_ry;
  logic                   s2_valid, s2_inside;
  logic [15:0]            s2_pix;
  logic                   s3_valid, s3_inside;
  logic [15:0]            s3_pix;

  logic [ADDR_WIDTH-1:0]  rom_addr_q;
  logic                   valid_out_q;
  logic [15:0]            pix_out_q;

  // A request arriving with frame_start already sees the new window
  logic [COORD_WIDTH-1:0] eff_x0, eff_y0;
  logic                   eff_en;
  logic [CW1-1:0]         px, py, x_lo, y_lo, x_hi, y_hi;
  logic                   inside_c;
  logic [ADDR_WIDTH-1:0]  addr_c;

  always_comb begin
    eff_x0   = frame_start ? cfg_x0 : x0_q;
    eff_y0   = frame_start ? cfg_y0 : y0_q;
    eff_en   = frame_start ? cfg_enable : en_q;
    px       = {1'b0, bus.pix_x};
    py       = {1'b0, bus.pix_y};
    x_lo     = {1'b0, eff_x0};
    y_lo     = {1'b0, eff_y0};
    // one extra bit so a window hanging off the right/bottom edge does not wrap
    x_hi     = x_lo + CW1'(IMG_W);
    y_hi     = y_lo + CW1'(IMG_H);
    inside_c = eff_en && (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);
    addr_c   = ADDR_WIDTH'(s1_ry) * ADDR_WIDTH'(IMG_W) + ADDR_WIDTH'(s1_rx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q        <= '0;
      y0_q        <= '0;
      fg_q        <= '0;
      bg_q        <= '0;
      tr_q        <= 1'b0;
      en_q        <= 1'b0;
      s1_valid    <= 1'b0;
      s1_inside   <= 1'b0;
      s1_pix      <= '0;
      s1_rx       <= '0;
      s1_ry       <= '0;
      s2_valid    <= 1'b0;
      s2_inside   <= 1'b0;
      s2_pix      <= '0;
      s3_valid    <= 1'b0;
      s3_inside   <= 1'b0;
      s3_pix      <= '0;
      rom_addr_q  <= '0;
      valid_out_q <= 1'b0;
      pix_out_q   <= '0;
    end else begin
      if (frame_start) begin
        x0_q <= cfg_x0;
        y0_q <= cfg_y0;
        fg_q <= cfg_fg;
        bg_q <= cfg_bg;
        tr_q <= cfg_transparent;
        en_q <= cfg_enable;
      end

      s1_valid  <= bus.pix_valid_in;
      s1_pix    <= bus.pix_in;
      s1_inside <= inside_c;
      s1_rx     <= bus.pix_x - eff_x0;
      s1_ry     <= bus.pix_y - eff_y0;

      s2_valid  <= s1_valid;
      s2_inside <= s1_inside;
      s2_pix    <= s1_pix;
      if (s1_valid)
        rom_addr_q <= s1_inside ? addr_c : '0;

      // ROM answers for the S2 address during this stage
      s3_valid  <= s2_valid;
      s3_inside <= s2_inside;
      s3_pix    <= s2_pix;

      valid_out_q <= s3_valid;
      if (s3_valid) begin
        if (!s3_inside)
          pix_out_q <= s3_pix;
        else if (bus.rom_data)
          pix_out_q <= fg_q;
        else if (tr_q)
          pix_out_q <= s3_pix;
        else
          pix_out_q <= bg_q;
      end
    end
  end

  assign bus.rom_addr      = rom_addr_q;
  assign bus.pix_valid_out = valid_out_q;
  assign bus.pix_out       = pix_out_q;
endmodule

// File: tb/tb_sign_overlay_renderer.sv
// tb/tb_sign_overlay_renderer.sv - directed vector bench for sign_overlay_renderer
module tb_sign_overlay_renderer;
  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic [9:0] cfg_x0, cfg_y0;
  logic [15:0] cfg_fg, cfg_bg;
  logic       cfg_transparent, cfg_enable;

  int pass_cnt = 0;
  int total_cnt = 0;

  sign_overlay_renderer_if #(.COORD_WIDTH(10), .ADDR_WIDTH(17)) bus ();

  sign_overlay_renderer dut (
    .clk             (clk),
    .rst             (rst),
    .frame_start     (frame_start),
    .cfg_x0          (cfg_x0),
    .cfg_y0          (cfg_y0),
    .cfg_fg          (cfg_fg),
    .cfg_bg          (cfg_bg),
    .cfg_transparent (cfg_transparent),
    .cfg_enable      (cfg_enable),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  // Bitmap: bit set at address 321 and wherever the low nibble is 0xA
  function automatic logic rom_bit(input logic [16:0] a);
    return (a == 17'd321) || (a[3:0] == 4'hA);
  endfunction

  always @(posedge clk) bus.rom_data <= rom_bit(bus.rom_addr);

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] pin;
    logic [16:0] addr;
    logic [15:0] pix;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic set_frame(input logic [9:0] x0, input logic [9:0] y0, input logic [15:0] fg,
                           input logic [15:0] bg, input logic tr, input logic en);
    cfg_x0 = x0; cfg_y0 = y0; cfg_fg = fg; cfg_bg = bg;
    cfg_transparent = tr; cfg_enable = en;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  // Starts and ends just after a clock edge with the pipeline empty
  task automatic single(input string nm, input logic [9:0] x, input logic [9:0] y,
                        input logic [15:0] pin, input logic [16:0] ea, input logic [15:0] ep,
                        input logic fs);
    bus.pix_valid_in = 1'b1; bus.pix_x = x; bus.pix_y = y; bus.pix_in = pin;
    frame_start = fs;
    @(posedge clk); #1;
    bus.pix_valid_in = 1'b0; frame_start = 1'b0;
    @(posedge clk); #1;
    chk({nm, " rom_addr"}, 32'(bus.rom_addr), 32'(ea));
    @(posedge clk); #1;
    chk({nm, " early valid"}, 32'(bus.pix_valid_out), 32'd0);
    @(posedge clk); #1;
    chk({nm, " valid"}, 32'(bus.pix_valid_out), 32'd1);
    chk({nm, " pix_out"}, 32'(bus.pix_out), 32'(ep));
  endtask

  function automatic logic [15:0] ref_pix(input int x, input int y, input logic [15:0] pin,
                                          input int x0, input int y0);
    int a;
    if (!(x >= x0 && x < x0 + 320 && y >= y0 && y < y0 + 240)) return pin;
    a = (y - y0) * 320 + (x - x0);
    return rom_bit(17'(a)) ? 16'hF800 : 16'h001F;
  endfunction

  initial begin
    logic       dv[10];
    int         dx[10];
    logic [15:0] dexp[10];
    int         sx[8];
    int         k;

    vt[0] = '{10'd10,  10'd5,   16'h1234, 17'd0,     16'h001F};
    vt[1] = '{10'd329, 10'd244, 16'h1111, 17'd76799, 16'h001F};
    vt[2] = '{10'd330, 10'd5,   16'h2222, 17'd0,     16'h2222};
    vt[3] = '{10'd9,   10'd5,   16'h3333, 17'd0,     16'h3333};
    vt[4] = '{10'd11,  10'd6,   16'h4444, 17'd321,   16'hF800};
    vt[5] = '{10'd12,  10'd6,   16'h07E0, 17'd322,   16'h001F};
    vt[6] = '{10'd10,  10'd4,   16'h5555, 17'd0,     16'h5555};
    vt[7] = '{10'd10,  10'd245, 16'h6666, 17'd0,     16'h6666};
    vt[8] = '{10'd20,  10'd5,   16'h7777, 17'd10,    16'hF800};
    vt[9] = '{10'd329, 10'd5,   16'h8888, 17'd319,   16'h001F};

    rst = 1'b1; frame_start = 1'b0;
    cfg_x0 = '0; cfg_y0 = '0; cfg_fg = '0; cfg_bg = '0;
    cfg_transparent = 1'b0; cfg_enable = 1'b0;
    bus.pix_valid_in = 1'b0; bus.pix_x = '0; bus.pix_y = '0; bus.pix_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("idle%0d rom_addr", i), 32'(bus.rom_addr), 32'd0);
      chk($sformatf("idle%0d valid", i), 32'(bus.pix_valid_out), 32'd0);
      chk($sformatf("idle%0d pix_out", i), 32'(bus.pix_out), 32'd0);
    end

    set_frame(10'd10, 10'd5, 16'hF800, 16'h001F, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      single($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].pin, vt[i].addr, vt[i].pix, 1'b0);

    set_frame(10'd10, 10'd5, 16'hF800, 16'h001F, 1'b1, 1'b1);
    single("transp bit0", 10'd12, 10'd6, 16'h07E0, 17'd322, 16'h07E0, 1'b0);
    single("transp bit1", 10'd11, 10'd6, 16'h0ABC, 17'd321, 16'hF800, 1'b0);

    set_frame(10'd709, 10'd0, 16'hF800, 16'h001F, 1'b0, 1'b1);
    single("edge origin in", 10'd1023, 10'd0, 16'h1357, 17'd314, 16'hF800, 1'b0);
    single("edge origin out", 10'd708, 10'd0, 16'h2468, 17'd0, 16'h2468, 1'b0);

    set_frame(10'd10, 10'd5, 16'hF800, 16'h001F, 1'b0, 1'b1);
    cfg_x0 = 10'd100;
    single("midframe cfg", 10'd10, 10'd5, 16'h9999, 17'd0, 16'h001F, 1'b0);
    set_frame(10'd10, 10'd5, 16'hF800, 16'h001F, 1'b0, 1'b0);
    single("disabled", 10'd11, 10'd6, 16'hABCD, 17'd0, 16'hABCD, 1'b0);

    cfg_x0 = 10'd50; cfg_y0 = 10'd50; cfg_enable = 1'b1;
    single("fs coincident", 10'd50, 10'd50, 16'h4242, 17'd0, 16'h001F, 1'b1);

    // Stream with a two-cycle bubble
    sx = '{11, 20, 330, 9, 26, 329, 12, 100};
    k = 0;
    for (int c = 0; c < 10; c++) begin
      dv[c] = !(c == 4 || c == 5);
      dx[c] = dv[c] ? sx[k] : 0;
      dexp[c] = ref_pix(dx[c], 6, 16'h1000 + 16'(c), 50, 50);
      if (dv[c]) k++;
    end
    set_frame(10'd10, 10'd5, 16'hF800, 16'h001F, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) dexp[c] = ref_pix(dx[c], 6, 16'h1000 + 16'(c), 10, 5);
    for (int c = 0; c < 14; c++) begin
      if (c >= 4) begin
        chk($sformatf("stream%0d valid", c), 32'(bus.pix_valid_out), 32'(dv[c-4]));
        if (dv[c-4])
          chk($sformatf("stream%0d pix", c), 32'(bus.pix_out), 32'(dexp[c-4]));
      end else begin
        chk($sformatf("stream%0d pre", c), 32'(bus.pix_valid_out), 32'd0);
      end
      if (c < 10) begin
        bus.pix_valid_in = dv[c]; bus.pix_x = 10'(dx[c]); bus.pix_y = 10'd6;
        bus.pix_in = 16'h1000 + 16'(c);
      end else begin
        bus.pix_valid_in = 1'b0;
      end
      @(posedge clk); #1;
    end

    // Reset with three requests in flight
    for (int i = 0; i < 3; i++) begin
      bus.pix_valid_in = 1'b1; bus.pix_x = 10'd11; bus.pix_y = 10'd6; bus.pix_in = 16'h5A5A;
      @(posedge clk); #1;
    end
    bus.pix_valid_in = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst pix_out", 32'(bus.pix_out), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rst flush%0d", i), 32'(bus.pix_valid_out), 32'd0);
      @(posedge clk); #1;
    end
    single("post rst", 10'd11, 10'd6, 16'hBEEF, 17'd0, 16'hBEEF, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/sign_overlay_renderer.md
Name: sign_overlay_renderer

Overview:
- Consumer stage placed directly after the 1-bit sign bitmap ROM.
- Accepts a streaming raster of LCD pixel requests (x, y, underlying RGB565 colour) from the LCD timing/compose path.
- Generates the ROM read address for pixels inside a movable sign window.
- Consumes the 1-bit ROM output and emits the composited RGB565 pixel with fixed pipeline latency.

Parameters:
- ADDR_WIDTH, 17, ROM address width; must satisfy IMG_W*IMG_H <= 2**ADDR_WIDTH.
- COORD_WIDTH, 10, width of screen x/y coordinates and origin.
- IMG_W, 320, sign bitmap width in pixels (row-major in ROM).
- IMG_H, 240, sign bitmap height in pixels.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse before first pixel of a frame; latches configuration.
- cfg_x0  in  COORD_WIDTH  sign window left edge (screen coordinates).
- cfg_y0  in  COORD_WIDTH  sign window top edge.
- cfg_fg  in  16  RGB565 colour for bitmap bit 1.
- cfg_bg  in  16  RGB565 colour for bitmap bit 0 when not transparent.
- cfg_transparent  in  1  1: bit 0 shows the underlying pixel instead of cfg_bg.
- cfg_enable  in  1  0: sign disabled; all pixels pass through.
- pix_valid_in  in  1  pixel request valid this cycle.
- pix_x  in  COORD_WIDTH  screen x of the request.
- pix_y  in  COORD_WIDTH  screen y of the request.
- pix_in  in  16  underlying RGB565 colour.
- rom_addr  out  ADDR_WIDTH  registered address to the bitmap ROM.
- rom_data  in  1  ROM output; valid one cycle after rom_addr.
- pix_valid_out  out  1  output pixel valid.
- pix_out  out  16  composited RGB565 colour.

Behaviour:
- Shadow config registers (x0, y0, fg, bg, transparent, enable) load only on a cycle where frame_start=1, so there is no tearing mid-frame. Cfg inputs are ignored on all other cycles.
- Reset values:
  - All shadow registers 0.
  - Pipeline valids 0.
  - rom_addr 0, pix_valid_out 0, pix_out 0.
- Pipeline: no backpressure, one request accepted per cycle, fixed latency of 4 cycles. A request sampled at edge N appears on pix_valid_out/pix_out after edge N+4.
  - S1 (edge N+1): register valid and pix_in. Compute inside = enable & (x >= x0) & (x < x0+IMG_W) & (y >= y0) & (y < y0+IMG_H), using COORD_WIDTH+1-bit sums so large origins do not wrap. Register rx = x-x0 and ry = y-y0.
  - S2 (edge N+2): rom_addr <= inside ? ry*IMG_W + rx : 0. The product is computed at ADDR_WIDTH width. rom_addr is only updated when S1 valid=1; otherwise it holds.
  - S3 (edge N+3): the ROM presents rom_data. Carry valid, inside and pix_in alongside.
  - S4 (edge N+4): pix_out <=
    - pix_in if !inside;
    - cfg_fg if rom_data=1;
    - pix_in if rom_data=0 and transparent=1;
    - else cfg_bg.
    pix_valid_out <= S3 valid.
- When pix_valid_out=0, pix_out holds its last value.
- Gaps in pix_valid_in propagate as bubbles with identical latency. Back-to-back requests are supported at full rate.
- The window may be partly off-screen; clipping follows naturally from the compare. A window starting at x0 = 2**COORD_WIDTH-IMG_W+k still computes inside correctly (no modulo wrap).
- Boundaries:
  - x = x0+IMG_W-1 is inside; x = x0+IMG_W is outside.
  - First pixel of window → address 0.
  - Last pixel → IMG_W*IMG_H-1 (76799 at defaults).
- frame_start coincident with pix_valid_in: the request in that cycle already uses the newly latched configuration.
- Reset asserted mid-stream clears all in-flight valids the next edge. No stale pixel is emitted after reset.

Test Plan:
- Reset, then idle → rom_addr=0, pix_valid_out=0, pix_out=0 for all cycles.
- frame_start with x0=10, y0=5, enable=1; request (10,5) → rom_addr=0 two cycles later, pix_valid_out=1 four cycles after request. Request (329,244) → rom_addr=76799; (330,5) and (9,5) → pix_out=pix_in.
- ROM model returning 1 at address 321, fg=F800, bg=001F, transparent=0: request (11,6) → pix_out=F800; (12,6) with bit 0 → 001F; set transparent=1 on next frame → same pixel outputs pix_in=07E0.
- Stream of 8 consecutive valid requests with 2-cycle gap inserted → output valid pattern identical to input pattern delayed exactly 4 cycles, colours match per-pixel reference model.
- Change cfg_x0 mid-frame without frame_start → no effect until next frame_start pulse; enable=0 → every pixel passes pix_in unchanged.
- Assert rst for one cycle with 3 requests in flight → pix_valid_out=0 the following cycles; the next post-reset request emerges with normal 4-cycle latency using reset configuration (enable=0, pass-through).
